vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Pixel-timing generator for the 640x480 @ 60 Hz VGA path.
- Divides the system clock down to a pixel-rate enable and runs horizontal and vertical position counters.
- Drives Posx/Posy to the character/blank memory stage and hsync/vsync to the VGA connector.
- Sits directly upstream of the memory stage; all timing in the display path derives from this block.

Parameters:
- DIV, 2, system clocks per pixel (50 MHz Clk to 25 MHz pixel rate); legal range 1..16.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VIS, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Posx  output  11  horizontal position, 0..H_TOT-1.
- Posy  output  11  vertical position, 0..V_TOT-1.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- video_on  output  1  high when Posx<H_VIS and Posy<V_VIS.
- pixel_tick  output  1  one-Clk pulse per pixel period.
- frame_start  output  1  one-Clk pulse when the counters wrap to (0,0).

Behaviour:
- Derived constants: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (default 800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (default 525).
- Reset: clock domain and reset
  - One clock domain (Clk). Reset is asynchronous and active-high.
  - Asserting reset immediately forces: div_cnt=0, Posx=0, Posy=0, hsync=vsync=~SYNC_POL (inactive), video_on=1, pixel_tick=0, frame_start=0.
  - Reset mid-frame aborts the frame. After release, counting restarts from (0,0).
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - pixel_tick is registered and is high during the Clk cycle in which div_cnt==DIV-1.
  - With DIV=1, pixel_tick is constantly high after reset, starting from the first edge.
- Counter advance:
  - Counters advance only on a Clk edge where pixel_tick is high.
  - Posx increments. At H_TOT-1, Posx wraps to 0 and Posy increments.
  - At Posy==V_TOT-1 together with the Posx wrap, Posy wraps to 0.
  - No other state changes Posx/Posy.
- Registered decode outputs:
  - hsync, vsync and video_on are registered, decoded from the next-state counter values.
  - They are therefore always consistent with the Posx/Posy values present in the same cycle. There is zero relative latency.
- Sync windows:
  - hsync is active when H_VIS+H_FP <= Posx <= H_VIS+H_FP+H_SYNC-1 (default 656..751).
  - vsync is active when V_VIS+V_FP <= Posy <= V_VIS+V_FP+V_SYNC-1 (default 490..491), for whole lines including Posx=0.
- Output stability:
  - Posx/Posy/video_on hold stable for DIV Clk cycles per pixel.
  - A downstream stage sampling on either Clk edge sees valid data when DIV>=2.
- frame_start:
  - Registered one-Clk pulse, high in the Clk cycle immediately following the edge where (Posx,Posy) became (0,0) via wrap.
  - Never asserted on reset release.
- Width: 11-bit counters cover totals up to 2047. H_TOT or V_TOT > 2047 is illegal. Elaboration fails (generate-time check).
- No other inputs; the block free-runs.

Test Plan:
- Reset values: assert reset mid-count at Posx=300, Posy=100.
  - Required response: outputs change immediately, without a Clk edge, to Posx=0, Posy=0, hsync=1, vsync=1, video_on=1, pixel_tick=0.
  - After release, the first pixel_tick occurs DIV Clk cycles later.
- Line timing, DIV=2:
  - pixel_tick period is exactly 2 Clk cycles.
  - Posx goes 0..799 then 0.
  - hsync is low for exactly 96 ticks, starting at Posx=656.
  - video_on falls at Posx=640.
- Frame timing:
  - Posy increments only on Posx 799->0.
  - vsync is low exactly while Posy is 490..491 (1600 pixel ticks).
  - video_on is low for all of Posy>=480.
  - The frame is 420000 pixel ticks.
- Wrap and frame_start:
  - At (799,524) the next tick produces (0,0).
  - frame_start pulses for exactly 1 Clk; there is no pulse at reset release.
  - The interval between pulses is 840000 Clk cycles.
- DIV=1 corner (H_VIS=4, H_FP=1, H_SYNC=2, H_BP=1, V_VIS=2, V_FP=1, V_SYNC=1, V_BP=1):
  - pixel_tick is constantly high.
  - Posx advances every Clk, cycle 0..7.
  - hsync is active at Posx 5..6; vsync is active at Posy 3.
- Polarity: SYNC_POL=1 -> hsync/vsync reset to 0 and assert high during the same windows as the default configuration.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider plus horizontal/vertical position counters
// and registered sync/blanking decode for a VGA raster (640x480 @ 60 Hz default).
//
// Ports:
//   Clk         system clock, all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   Posx        horizontal position, 0..H_TOT-1
//   Posy        vertical position, 0..V_TOT-1
//   hsync       horizontal sync, active level SYNC_POL
//   vsync       vertical sync, active level SYNC_POL
//   video_on    high while (Posx,Posy) lies in the visible area
//   pixel_tick  one-Clk pulse per pixel period
//   frame_start one-Clk pulse after the counters wrap to (0,0)
module vga_sync_gen #(
    parameter int DIV      = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        Clk,
    input  logic        reset,
    output logic [10:0] Posx,
    output logic [10:0] Posy,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pixel_tick,
    output logic        frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [10:0] X_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] Y_LAST = 11'(V_TOT - 1);
    localparam logic [10:0] X_VIS  = 11'(H_VIS);
    localparam logic [10:0] Y_VIS  = 11'(V_VIS);
    localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_BEG = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END = 11'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
    localparam logic POL = (SYNC_POL != 0);

    // 11-bit position counters cannot represent larger rasters.
    generate
        if (H_TOT > 2047 || V_TOT > 2047) begin : g_bad_total
            $error("vga_sync_gen: H_TOT/V_TOT exceed 11-bit counter range");
        end
        if (DIV < 1 || DIV > 16) begin : g_bad_div
            $error("vga_sync_gen: DIV must be in 1..16");
        end
    endgenerate

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [10:0]   x_nxt;
    logic [10:0]   y_nxt;
    logic          hs_act;
    logic          vs_act;
    logic          vis_nxt;
    logic          wrap;

    always_comb begin
        div_nxt = (div_cnt == D_LAST) ? '0 : div_cnt + DW'(1);
        x_nxt   = Posx;
        y_nxt   = Posy;
        wrap    = 1'b0;
        if (pixel_tick) begin
            if (Posx == X_LAST) begin
                x_nxt = '0;
                if (Posy == Y_LAST) begin
                    y_nxt = '0;
                    wrap  = 1'b1;
                end else begin
                    y_nxt = Posy + 11'd1;
                end
            end else begin
                x_nxt = Posx + 11'd1;
            end
        end
    end

    // Decode from the next-state counters so the registered sync and
    // blanking outputs line up with the Posx/Posy they accompany.
    always_comb begin
        hs_act  = (x_nxt >= HS_BEG) && (x_nxt <= HS_END);
        vs_act  = (y_nxt >= VS_BEG) && (y_nxt <= VS_END);
        vis_nxt = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            pixel_tick  <= 1'b0;
            Posx        <= '0;
            Posy        <= '0;
            hsync       <= ~POL;
            vsync       <= ~POL;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            // tick is high in the cycle where div_cnt sits at DIV-1
            pixel_tick  <= (div_nxt == D_LAST);
            Posx        <= x_nxt;
            Posy        <= y_nxt;
            hsync       <= hs_act ? POL : ~POL;
            vsync       <= vs_act ? POL : ~POL;
            video_on    <= vis_nxt;
            frame_start <= wrap;
        end
    end

endmodule
